vlsu_obi_arbiter: RTL
=====================

Name: vlsu_obi_arbiter

Overview:
- Shares the single OBI data-memory slave port between two masters: the scalar core LSU (master 0) and the vector LSU (master 1).
- Arbitrates address-phase requests.
- Tracks outstanding transactions in issue order so each rvalid/rdata response returns to the master that issued it.
- Sits between the core/accelerator top level and the data memory; the vector LSU connects its OBI master port here, not directly to memory.

Parameters:
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions tracked; power of two, ≥1.

Ports:
- clk  input  1  clock.
- n_reset  input  1  asynchronous active-low reset.
- core_req_i  input  1  core address-phase request.
- core_gnt_o  output  1  core grant.
- core_addr_i  input  32  core address.
- core_we_i  input  1  core write enable.
- core_be_i  input  4  core byte enables.
- core_wdata_i  input  32  core write data.
- core_rvalid_o  output  1  core response valid.
- core_rdata_o  output  32  core read data.
- vlsu_req_i  input  1  vector LSU request.
- vlsu_gnt_o  output  1  vector LSU grant.
- vlsu_addr_i  input  32  vector LSU address.
- vlsu_we_i  input  1  vector LSU write enable.
- vlsu_be_i  input  4  vector LSU byte enables.
- vlsu_wdata_i  input  32  vector LSU write data.
- vlsu_rvalid_o  output  1  vector LSU response valid.
- vlsu_rdata_o  output  32  vector LSU read data.
- vlsu_lock_i  input  1  vector LSU owns the port exclusively; asserted by the LSU while its load sequence is active.
- data_req_o  output  1  memory request.
- data_gnt_i  input  1  memory grant.
- data_addr_o  output  32  memory address.
- data_we_o  output  1  memory write enable.
- data_be_o  output  4  memory byte enables.
- data_wdata_o  output  32  memory write data.
- data_rvalid_i  input  1  memory response valid.
- data_rdata_i  input  32  memory read data.
- protocol_err_o  output  1  sticky; set on a response with no outstanding transaction.

Behaviour:
- **Reset values:** all outputs 0; selection register = core; last-grant = VLSU, so the core wins the first conflict; outstanding FIFO empty; protocol_err_o 0.
- **Selection**, evaluated each cycle when no transaction is held:
  - vlsu_lock_i=1: VLSU is the only eligible master; core_gnt_o held 0 even if core_req_i=1.
  - Otherwise, if only one master requests, it is selected.
  - If both request, round-robin: the master not granted last.
- **Hold rule (OBI address-phase stability):**
  - If data_req_o=1 and data_gnt_i=0, the selection is registered and kept until data_gnt_i=1.
  - No re-arbitration occurs while held, even if vlsu_lock_i rises.
- **Forwarding:**
  - data_req_o = selected master's req AND FIFO not full.
  - data_addr_o, data_we_o, data_be_o and data_wdata_o are muxed combinationally from the selected master.
  - When data_req_o=0, those data outputs are 0.
- **Grant:**
  - Selected master's gnt_o = data_gnt_i AND data_req_o. The other master's gnt_o = 0. Zero-cycle combinational path.
  - On a granted cycle: push the selected master ID into the FIFO and update last-grant.
- **Response:**
  - On data_rvalid_i: pop the FIFO head.
  - Assert the head master's rvalid_o in the same cycle (combinational); rdata_o of that master = data_rdata_i.
  - The non-addressed master sees rvalid_o=0 and rdata_o=0.
- **FIFO:**
  - Depth MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.
  - Simultaneous push and pop: count unchanged, head advances.
  - Full blocks new requests (data_req_o=0), except that a pop and a push in the same cycle are never both needed when full: full blocks the request regardless of a concurrent pop (no bypass).
- **Error:** data_rvalid_i while the FIFO is empty sets protocol_err_o. That response is dropped (no rvalid_o). The flag clears only on reset.
- **Lock dropped mid-stream:** outstanding VLSU responses still route to the VLSU via the FIFO. The core may be granted the next cycle; ordering is preserved by the FIFO.
- **Reset mid-operation:** FIFO, selection and flags are cleared asynchronously. In-flight responses arriving after reset set protocol_err_o.
- **Latency:** arbitration adds 0 cycles; responses add 0 cycles.

Decomposition:
- **accelerator_pkg** gains:
  - typedef enum logic {OBI_CORE=1'b0, OBI_VLSU=1'b1} obi_master_e;
  - localparam OBI_MAX_OUTSTANDING = 2.
- **Sub-module obi_id_fifo:** parameterised-depth FIFO of obi_master_e with push, pop, head, full, empty. The arbiter instantiates one.

Test Plan:
- Core only, memory grants immediately, rvalid 1 cycle later with rdata 0xDEADBEEF → core_gnt_o=1 in the req cycle; core_rvalid_o=1 with core_rdata_o=0xDEADBEEF; vlsu_rvalid_o stays 0.
- Both request every cycle, lock=0, gnt always 1, rvalid 1 cycle after gnt → grants alternate core, VLSU, core, VLSU…; responses route in the same order.
- VLSU holds req with data_gnt_i=0 for 3 cycles while core_req_i rises → data_addr_o stays the VLSU address and core_gnt_o=0 until the VLSU grant on cycle 4; the core is granted next.
- vlsu_lock_i=1, both request for 4 cycles → 4 consecutive VLSU grants, core_gnt_o=0 throughout; after lock drops, the core is granted the next cycle.
- Memory withholds rvalid with MAX_OUTSTANDING=2, two grants issued → data_req_o=0 on the third request; a single rvalid re-enables data_req_o the following cycle.
- data_rvalid_i pulse with the FIFO empty → protocol_err_o=1 persists, no rvalid_o on either master; n_reset pulse → protocol_err_o=0, all outputs 0.

Source files
------------

// File: rtl/accelerator_pkg.sv
// ============================================================================
// accelerator_pkg : shared types for the accelerator / vector LSU memory path
// Revision: 1.0
// ============================================================================
`default_nettype none

package accelerator_pkg;

  typedef enum logic {
    OBI_CORE = 1'b0,
    OBI_VLSU = 1'b1
  } obi_master_e;

  localparam int OBI_MAX_OUTSTANDING = 2;

endpackage

`default_nettype wire

// File: rtl/obi_id_fifo.sv
// ============================================================================
// obi_id_fifo : in-order queue of master IDs for granted, unanswered requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module obi_id_fifo
  import accelerator_pkg::*;
#(
  parameter int DEPTH = OBI_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        push,
  input  obi_master_e push_id,
  input  logic        pop,
  output obi_master_e head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  obi_master_e        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= OBI_CORE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_id;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      // Concurrent push and pop leaves the occupancy unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vlsu_obi_arbiter.sv
// ============================================================================
// vlsu_obi_arbiter : shares the OBI data port between core LSU and vector LSU
// Revision: 1.0
// ============================================================================
`default_nettype none

module vlsu_obi_arbiter
  import accelerator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = OBI_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        n_reset,

  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,

  input  logic        vlsu_req_i,
  output logic        vlsu_gnt_o,
  input  logic [31:0] vlsu_addr_i,
  input  logic        vlsu_we_i,
  input  logic [3:0]  vlsu_be_i,
  input  logic [31:0] vlsu_wdata_i,
  output logic        vlsu_rvalid_o,
  output logic [31:0] vlsu_rdata_o,
  input  logic        vlsu_lock_i,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,

  output logic        protocol_err_o
);

  obi_master_e r_sel;
  obi_master_e r_last_grant;
  logic        r_held;
  logic        r_protocol_err;

  obi_master_e w_sel;
  obi_master_e w_head;
  logic        w_sel_req;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_grant;
  logic        w_pop;

  // An ungranted request freezes the selection so the address phase stays stable.
  always_comb begin
    w_sel = OBI_CORE;
    if (r_held) begin
      w_sel = r_sel;
    end else if (vlsu_lock_i) begin
      w_sel = OBI_VLSU;
    end else if (core_req_i && vlsu_req_i) begin
      w_sel = (r_last_grant == OBI_CORE) ? OBI_VLSU : OBI_CORE;
    end else if (vlsu_req_i) begin
      w_sel = OBI_VLSU;
    end
  end

  assign w_sel_req  = (w_sel == OBI_VLSU) ? vlsu_req_i : core_req_i;
  assign data_req_o = w_sel_req && !w_fifo_full;
  assign w_grant    = data_req_o && data_gnt_i;

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      if (w_sel == OBI_VLSU) begin
        data_addr_o  = vlsu_addr_i;
        data_we_o    = vlsu_we_i;
        data_be_o    = vlsu_be_i;
        data_wdata_o = vlsu_wdata_i;
      end else begin
        data_addr_o  = core_addr_i;
        data_we_o    = core_we_i;
        data_be_o    = core_be_i;
        data_wdata_o = core_wdata_i;
      end
    end
  end

  assign core_gnt_o = w_grant && (w_sel == OBI_CORE);
  assign vlsu_gnt_o = w_grant && (w_sel == OBI_VLSU);

  // A response with nothing outstanding is dropped and only flags the error.
  assign w_pop         = data_rvalid_i && !w_fifo_empty;
  assign core_rvalid_o = w_pop && (w_head == OBI_CORE);
  assign vlsu_rvalid_o = w_pop && (w_head == OBI_VLSU);
  assign core_rdata_o  = core_rvalid_o ? data_rdata_i : '0;
  assign vlsu_rdata_o  = vlsu_rvalid_o ? data_rdata_i : '0;
  assign protocol_err_o = r_protocol_err;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (w_grant),
    .push_id (w_sel),
    .pop     (w_pop),
    .head    (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sel          <= OBI_CORE;
      r_last_grant   <= OBI_VLSU;
      r_held         <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_sel  <= w_sel;
      r_held <= data_req_o && !data_gnt_i;
      if (w_grant) r_last_grant <= w_sel;
      if (data_rvalid_i && w_fifo_empty) r_protocol_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire
